// File: rtl/rca_sub_seq_if.sv
// Streaming bundle for the sequential ripple subtractor: an operand channel and a
// result channel, each with its own valid/ready handshake.
interface rca_sub_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  // Source of operands and sink of results.
  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );

  // The subtractor itself.
  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );
endinterface

// File: rtl/rca_sub_seq.sv
// Multi-cycle ripple subtractor: diff = a - b - b_in, one SLICE-bit slice per clock,
// LSB slice first, with the borrow carried between cycles in a single register.
module rca_sub_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 4
) (
  input logic        clk,
  input logic        rst_n,
  rca_sub_seq_if.slave bus
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("rca_sub_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q;
  logic               overflow_q;

  logic               accept;
  logic               last_slice;
  logic [IDX_W-1:0]   base;
  logic [SLICE-1:0]   a_slice;
  logic [SLICE-1:0]   b_slice;
  logic [SLICE:0]     slice_res;
  logic [SLICE-1:0]   slice_d;
  logic               slice_br;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign last_slice = (state_q == RUN) && (cnt_q == LAST_SLICE);

  // One extra bit on the slice subtraction; its top bit is the outgoing borrow.
  assign base      = IDX_W'(cnt_q) * IDX_W'(SLICE);
  assign a_slice   = a_q[base +: SLICE];
  assign b_slice   = b_q[base +: SLICE];
  assign slice_res = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE{1'b0}}, borrow_q};
  assign slice_d   = slice_res[SLICE-1:0];
  assign slice_br  = slice_res[SLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_slice)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Operands stay frozen from acceptance until the next acceptance; results are
  // only rewritten slice by slice during RUN, so they hold through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      borrow_q <= bus.b_in;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      diff_q[base +: SLICE] <= slice_d;
      borrow_q              <= slice_br;
      cnt_q                 <= cnt_q + 1'b1;
      if (last_slice) begin
        borrow_out_q <= slice_br;
        overflow_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_d[SLICE-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_rca_sub_seq.sv
// Scoreboard bench for rca_sub_seq: directed operands push expected results into a
// queue, and an independent monitor pops and compares whenever a result is consumed.
module tb_rca_sub_seq;

  localparam int WIDTH   = 64;
  localparam int SLICE   = 4;
  localparam int LATENCY = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             ov;
    int               acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_seen;

  rca_sub_seq_if #(.WIDTH(WIDTH)) bus ();

  rca_sub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present operands, wait (bounded) for in_ready, and record the expected result
  // at the acceptance edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic b_in, input logic [WIDTH-1:0] exp_diff,
                                input logic exp_bo, input logic exp_ov);
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.b_in     = b_in;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("accept_timeout", WIDTH'(ok), WIDTH'(1));
    if (ok) begin
      @(posedge clk);
      #1;
      e.diff    = exp_diff;
      e.bo      = exp_bo;
      e.ov      = exp_ov;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_output("drain_timeout", WIDTH'(exp_q.size()), WIDTH'(0));
  endtask

  // Monitor: latency on the rising of out_valid, values when the result is consumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!mon_seen) begin
        mon_seen = 1'b1;
        check_output("queue_depth", WIDTH'(exp_q.size()), WIDTH'(1));
        if (exp_q.size() > 0)
          check_output("latency", WIDTH'(cyc - exp_q[0].acc_cyc), WIDTH'(LATENCY));
      end
      if (bus.out_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_output("diff", bus.diff, mon_e.diff);
        check_output("borrow_out", WIDTH'(bus.borrow_out), WIDTH'(mon_e.bo));
        check_output("overflow", WIDTH'(bus.overflow), WIDTH'(mon_e.ov));
      end
    end else begin
      mon_seen = 1'b0;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check_output("rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    check_output("rst_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    check_output("rst_diff", bus.diff, WIDTH'(0));
    check_output("rst_borrow_out", WIDTH'(bus.borrow_out), WIDTH'(0));
    check_output("rst_overflow", WIDTH'(bus.overflow), WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    wait_drain();
    apply_stimulus(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_drain();
    apply_stimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    wait_drain();
    apply_stimulus(64'h0000_0001_0000_0000, 64'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    wait_drain();
    apply_stimulus(64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                   64'h0000_0000_0000_1234, 1'b1, 1'b0);
    wait_drain();
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                   64'h8000_0000_0000_0000, 1'b1, 1'b1);
    wait_drain();

    // Back-pressure: result held in DONE while new operands wait on the input.
    @(negedge clk);
    bus.out_ready = 1'b0;
    apply_stimulus(64'd100, 64'd58, 1'b1, 64'd41, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("bp_valid_timeout", WIDTH'(ok), WIDTH'(1));
    bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b        = 64'h0123_4567_89AB_CDEF;
    bus.b_in     = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_output("bp_in_ready", WIDTH'(bus.in_ready), WIDTH'(0));
      check_output("bp_out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
      check_output("bp_diff_hold", bus.diff, 64'd41);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_idle_after_release", WIDTH'(bus.in_ready), WIDTH'(1));
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0,
                   64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    wait_drain();

    // Reset pulsed between edges with the counter at 7.
    @(negedge clk);
    bus.a        = 64'hDEAD_BEEF_0000_FFFF;
    bus.b        = 64'h1111_2222_3333_4444;
    bus.b_in     = 1'b1;
    bus.in_valid = 1'b1;
    check_output("mid_rst_ready_before", WIDTH'(bus.in_ready), WIDTH'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    check_output("mid_rst_diff", bus.diff, WIDTH'(0));
    check_output("mid_rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    check_output("mid_rst_borrow_out", WIDTH'(bus.borrow_out), WIDTH'(0));
    #1;
    rst_n = 1'b1;
    apply_stimulus(64'd10, 64'd10, 1'b0, 64'd0, 1'b0, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
